// File: rtl/bbq_pair_sched.sv
// bbq_pair_sched: issue controller for a pair of BBQ priority queues.
// Each cycle it picks at most one enqueue and one dequeue-max, balancing
// occupancy between the two queues and gating dequeues on downstream credits.

package bbq_pair_sched_pkg;
    typedef enum logic {
        HEAP_OP_ENQUE     = 1'b0,
        HEAP_OP_DEQUE_MAX = 1'b1
    } heap_op_t;
endpackage

module bbq_pair_sched
    import bbq_pair_sched_pkg::*;
#(
    parameter int DWIDTH      = 32,
    parameter int CAPACITY    = 16,
    parameter int ISSUE_GAP   = 2,
    parameter int OUT_CREDITS = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [DWIDTH-1:0]                    in_data,
    input  logic [5:0]                           in_prior,
    input  logic [1:0]                           bbq_rdy,
    output logic                                 q0_valid,
    output heap_op_t                             q0_op_type,
    output logic [DWIDTH-1:0]                    q0_he_data,
    output logic [5:0]                           q0_he_priority,
    output logic                                 q1_valid,
    output heap_op_t                             q1_op_type,
    output logic [DWIDTH-1:0]                    q1_he_data,
    output logic [5:0]                           q1_he_priority,
    input  logic                                 credit_ret,
    output logic [$clog2(2*CAPACITY+1)-1:0]      occ_total,
    output logic                                 credit_err
);

    localparam int OW = $clog2(CAPACITY + 1);
    localparam int GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
    localparam int CW = (OUT_CREDITS > 0) ? $clog2(OUT_CREDITS + 1) : 1;
    localparam int TW = $clog2(2 * CAPACITY + 1);

    localparam logic [OW-1:0] CAP_V      = OW'(CAPACITY);
    localparam logic [GW-1:0] GAP_RELOAD = GW'(ISSUE_GAP - 1);
    localparam logic [CW-1:0] CRED_MAX   = CW'(OUT_CREDITS);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Registered state
    state_t              state_q;
    logic                rr_q;
    logic [OW-1:0]       occ_q [2];
    logic [GW-1:0]       gap_q [2];
    logic [CW-1:0]       cred_q;
    logic                err_q;
    logic [TW-1:0]       occ_total_q;
    logic                vld_q  [2];
    heap_op_t            op_q   [2];
    logic [DWIDTH-1:0]   data_q [2];
    logic [5:0]          prio_q [2];

    // Next-state / decision signals
    logic [OW-1:0]       occ_d [2];
    logic [GW-1:0]       gap_d [2];
    logic [CW-1:0]       cred_d;
    logic [1:0]          elig;
    logic [1:0]          can_enq;
    logic [1:0]          can_deq;
    logic [1:0]          enq_hit;
    logic [1:0]          deq_hit;
    logic [1:0]          deq_cand;
    logic [1:0]          deq_other;
    logic                enq_has;
    logic                enq_tgt;
    logic                deq_want;
    logic                deq_tgt;
    logic                conflict;
    logic                ready_c;
    logic                enq_go;
    logic                deq_go;
    logic                rr_flip;
    logic                ret_ok;

    // Per-queue eligibility and counter next-state
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_q
            assign elig[gi]    = (state_q == ST_RUN) && bbq_rdy[gi] && (gap_q[gi] == '0);
            assign can_enq[gi] = elig[gi] && (occ_q[gi] < CAP_V);
            assign can_deq[gi] = elig[gi] && (occ_q[gi] != '0);
            assign enq_hit[gi] = enq_go && (enq_tgt == 1'(gi));
            assign deq_hit[gi] = deq_go && (deq_tgt == 1'(gi));
            assign occ_d[gi]   = occ_q[gi] + OW'(enq_hit[gi]) - OW'(deq_hit[gi]);
            assign gap_d[gi]   = (enq_hit[gi] || deq_hit[gi]) ? GAP_RELOAD :
                                 (gap_q[gi] != '0) ? (gap_q[gi] - GW'(1)) : gap_q[gi];
        end
    endgenerate

    // Choose enqueue/dequeue targets and resolve a shared-queue conflict
    always_comb begin
        enq_has   = |can_enq;
        enq_tgt   = 1'b0;
        deq_want  = 1'b0;
        deq_tgt   = 1'b0;
        deq_other = 2'b00;
        deq_cand  = can_deq;
        conflict  = 1'b0;

        // Lower occupancy gets the enqueue; queue 0 on a tie
        if (can_enq == 2'b10) begin
            enq_tgt = 1'b1;
        end else if (can_enq == 2'b11) begin
            enq_tgt = (occ_q[1] < occ_q[0]);
        end

        deq_want = (cred_q != '0) && (|can_deq);

        // Steer the dequeue away from the enqueue target when possible
        if (enq_has) begin
            deq_other = can_deq & (enq_tgt ? 2'b01 : 2'b10);
            if (deq_other != 2'b00) begin
                deq_cand = deq_other;
            end
        end

        // Higher occupancy gets the dequeue; queue 0 on a tie
        if (deq_cand == 2'b10) begin
            deq_tgt = 1'b1;
        end else if (deq_cand == 2'b11) begin
            deq_tgt = (occ_q[1] > occ_q[0]);
        end

        conflict = enq_has && deq_want && (enq_tgt == deq_tgt);
    end

    // Issue decisions: an idle enqueue slot hands the queue to the dequeue
    assign ready_c  = enq_has && !(conflict && rr_q);
    assign enq_go   = in_valid && ready_c;
    assign deq_go   = deq_want && (!conflict || rr_q || !in_valid);
    assign rr_flip  = conflict && (rr_q ? deq_go : enq_go);

    // Credit accounting; a return at the full budget is dropped
    assign ret_ok = credit_ret && (cred_q != CRED_MAX);
    always_comb begin
        cred_d = cred_q;
        if (ret_ok && !deq_go) begin
            cred_d = cred_q + CW'(1);
        end else if (!ret_ok && deq_go) begin
            cred_d = cred_q - CW'(1);
        end
    end

    // State machine, counters and registered op outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_INIT;
            rr_q        <= 1'b0;
            cred_q      <= CRED_MAX;
            err_q       <= 1'b0;
            occ_total_q <= '0;
            for (int q = 0; q < 2; q++) begin
                occ_q[q]  <= '0;
                gap_q[q]  <= '0;
                vld_q[q]  <= 1'b0;
                op_q[q]   <= HEAP_OP_ENQUE;
                data_q[q] <= '0;
                prio_q[q] <= '0;
            end
        end else begin
            case (state_q)
                ST_INIT: if (bbq_rdy == 2'b11) state_q <= ST_RUN;
                default: state_q <= ST_RUN;
            endcase
            rr_q        <= rr_q ^ rr_flip;
            cred_q      <= cred_d;
            err_q       <= err_q | (credit_ret && (cred_q == CRED_MAX));
            occ_total_q <= TW'(occ_d[0]) + TW'(occ_d[1]);
            for (int q = 0; q < 2; q++) begin
                occ_q[q] <= occ_d[q];
                gap_q[q] <= gap_d[q];
                if (enq_hit[q]) begin
                    vld_q[q]  <= 1'b1;
                    op_q[q]   <= HEAP_OP_ENQUE;
                    data_q[q] <= in_data;
                    prio_q[q] <= in_prior;
                end else if (deq_hit[q]) begin
                    vld_q[q]  <= 1'b1;
                    op_q[q]   <= HEAP_OP_DEQUE_MAX;
                    data_q[q] <= '0;
                    prio_q[q] <= '0;
                end else begin
                    vld_q[q]  <= 1'b0;
                    op_q[q]   <= HEAP_OP_ENQUE;
                    data_q[q] <= '0;
                    prio_q[q] <= '0;
                end
            end
        end
    end

    assign in_ready       = ready_c;
    assign occ_total      = occ_total_q;
    assign credit_err     = err_q;
    assign q0_valid       = vld_q[0];
    assign q0_op_type     = op_q[0];
    assign q0_he_data     = data_q[0];
    assign q0_he_priority = prio_q[0];
    assign q1_valid       = vld_q[1];
    assign q1_op_type     = op_q[1];
    assign q1_he_data     = data_q[1];
    assign q1_he_priority = prio_q[1];

endmodule

// File: tb/tb_bbq_pair_sched.sv
// tb_bbq_pair_sched: directed scenarios against four parameterisations of
// bbq_pair_sched sharing one clock and one set of input drivers.
module tb_bbq_pair_sched;
    import bbq_pair_sched_pkg::*;

    // Packed observation codes: {q0_valid, q0_is_deq, q1_valid, q1_is_deq}
    localparam logic [3:0] NONE = 4'b0000;
    localparam logic [3:0] Q0E  = 4'b1000;
    localparam logic [3:0] Q0D  = 4'b1100;
    localparam logic [3:0] Q1E  = 4'b0010;
    localparam logic [3:0] Q1D  = 4'b0011;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic [5:0]  in_prior = '0;
    logic [1:0]  bbq_rdy = 2'b00;
    logic        credit_ret = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Outputs of the four instances: d_ default, a_ alternate, c_ capacity, k_ credit
    logic d_rdy, d_v0, d_v1, d_err; heap_op_t d_op0, d_op1;
    logic [31:0] d_dat0, d_dat1; logic [5:0] d_pr0, d_pr1; logic [5:0] d_occ;
    logic a_rdy, a_v0, a_v1, a_err; heap_op_t a_op0, a_op1;
    logic [31:0] a_dat0, a_dat1; logic [5:0] a_pr0, a_pr1; logic [5:0] a_occ;
    logic c_rdy, c_v0, c_v1, c_err; heap_op_t c_op0, c_op1;
    logic [31:0] c_dat0, c_dat1; logic [5:0] c_pr0, c_pr1; logic [2:0] c_occ;
    logic k_rdy, k_v0, k_v1, k_err; heap_op_t k_op0, k_op1;
    logic [31:0] k_dat0, k_dat1; logic [5:0] k_pr0, k_pr1; logic [5:0] k_occ;

    wire [3:0] d_obs = {d_v0, d_v0 & d_op0, d_v1, d_v1 & d_op1};
    wire [3:0] a_obs = {a_v0, a_v0 & a_op0, a_v1, a_v1 & a_op1};
    wire [3:0] c_obs = {c_v0, c_v0 & c_op0, c_v1, c_v1 & c_op1};
    wire [3:0] k_obs = {k_v0, k_v0 & k_op0, k_v1, k_v1 & k_op1};

    bbq_pair_sched #(.DWIDTH(32), .CAPACITY(16), .ISSUE_GAP(2), .OUT_CREDITS(8)) u_def (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_rdy), .in_data(in_data),
        .in_prior(in_prior), .bbq_rdy(bbq_rdy), .q0_valid(d_v0), .q0_op_type(d_op0),
        .q0_he_data(d_dat0), .q0_he_priority(d_pr0), .q1_valid(d_v1), .q1_op_type(d_op1),
        .q1_he_data(d_dat1), .q1_he_priority(d_pr1), .credit_ret(credit_ret),
        .occ_total(d_occ), .credit_err(d_err));

    bbq_pair_sched #(.DWIDTH(32), .CAPACITY(16), .ISSUE_GAP(1), .OUT_CREDITS(0)) u_alt (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_rdy), .in_data(in_data),
        .in_prior(in_prior), .bbq_rdy(bbq_rdy), .q0_valid(a_v0), .q0_op_type(a_op0),
        .q0_he_data(a_dat0), .q0_he_priority(a_pr0), .q1_valid(a_v1), .q1_op_type(a_op1),
        .q1_he_data(a_dat1), .q1_he_priority(a_pr1), .credit_ret(credit_ret),
        .occ_total(a_occ), .credit_err(a_err));

    bbq_pair_sched #(.DWIDTH(32), .CAPACITY(2), .ISSUE_GAP(1), .OUT_CREDITS(1)) u_cap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_rdy), .in_data(in_data),
        .in_prior(in_prior), .bbq_rdy(bbq_rdy), .q0_valid(c_v0), .q0_op_type(c_op0),
        .q0_he_data(c_dat0), .q0_he_priority(c_pr0), .q1_valid(c_v1), .q1_op_type(c_op1),
        .q1_he_data(c_dat1), .q1_he_priority(c_pr1), .credit_ret(credit_ret),
        .occ_total(c_occ), .credit_err(c_err));

    bbq_pair_sched #(.DWIDTH(32), .CAPACITY(16), .ISSUE_GAP(1), .OUT_CREDITS(2)) u_cr2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(k_rdy), .in_data(in_data),
        .in_prior(in_prior), .bbq_rdy(bbq_rdy), .q0_valid(k_v0), .q0_op_type(k_op0),
        .q0_he_data(k_dat0), .q0_he_priority(k_pr0), .q1_valid(k_v1), .q1_op_type(k_op1),
        .q1_he_data(k_dat1), .q1_he_priority(k_pr1), .credit_ret(credit_ret),
        .occ_total(k_occ), .credit_err(k_err));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0; in_valid = 1'b0; credit_ret = 1'b0; bbq_rdy = 2'b00;
        in_data = '0; in_prior = '0;
        tick;
        tick;
        rst = 1'b1;
    endtask

    task automatic test_reset;
        do_reset;
        if (d_rdy !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", d_rdy); end
        checks++;
        if (d_obs !== NONE) begin errors++; $display("FAIL rst_valid: got %b want %b", d_obs, NONE); end
        checks++;
        if ({d_op0, d_op1} !== {HEAP_OP_ENQUE, HEAP_OP_ENQUE}) begin
            errors++; $display("FAIL rst_optype: got %b%b want 00", d_op0, d_op1);
        end
        checks++;
        if ({d_dat0, d_dat1, d_pr0, d_pr1} !== 76'd0) begin
            errors++; $display("FAIL rst_data: got %h want 0", {d_dat0, d_dat1, d_pr0, d_pr1});
        end
        checks++;
        if ({d_occ, d_err} !== 7'd0) begin
            errors++; $display("FAIL rst_occ_err: got occ %0d err %b want 0 0", d_occ, d_err);
        end
        checks++;
        // Stay in INIT while the queues are not ready, even with a request pending
        in_valid = 1'b1; in_data = 32'h1234_5678; in_prior = 6'd42;
        for (int i = 0; i < 5; i++) begin
            tick;
            if ({d_rdy, d_obs} !== 5'b0_0000) begin
                errors++; $display("FAIL init_idle[%0d]: got ready %b ops %b want 0 0000", i, d_rdy, d_obs);
            end
            checks++;
        end
        bbq_rdy = 2'b11;
        tick;
        if ({d_rdy, d_obs} !== 5'b1_0000) begin
            errors++; $display("FAIL init_to_run: got ready %b ops %b want 1 0000", d_rdy, d_obs);
        end
        checks++;
        tick;
        if (d_obs !== Q0E || d_dat0 !== 32'h1234_5678 || d_pr0 !== 6'd42) begin
            errors++; $display("FAIL first_enq: got ops %b data %h prio %0d want %b 12345678 42", d_obs, d_dat0, d_pr0, Q0E);
        end
        checks++;
        in_valid = 1'b0;
    endtask

    task automatic test_single_queue_rr;
        logic [3:0] exp_obs [7];
        logic       exp_rdy [7];
        exp_obs = '{Q0E, NONE, Q0E, NONE, Q0D, NONE, Q0E};
        exp_rdy = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset;
        bbq_rdy = 2'b11;
        tick;
        bbq_rdy = 2'b01; in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_data = 32'hB000_0000 + i; in_prior = 6'(i + 1);
            if (d_rdy !== exp_rdy[i]) begin
                errors++; $display("FAIL rr_ready[%0d]: got %b want %b", i, d_rdy, exp_rdy[i]);
            end
            checks++;
            tick;
            if (d_obs !== exp_obs[i]) begin
                errors++; $display("FAIL rr_ops[%0d]: got %b want %b", i, d_obs, exp_obs[i]);
            end
            checks++;
        end
        if (d_occ !== 6'd2) begin errors++; $display("FAIL rr_occ: got %0d want 2", d_occ); end
        checks++;
        in_valid = 1'b0;
    endtask

    task automatic test_credit_err;
        do_reset;
        bbq_rdy = 2'b11;
        tick;
        if (d_err !== 1'b0) begin errors++; $display("FAIL cerr_pre: got %b want 0", d_err); end
        checks++;
        credit_ret = 1'b1;
        tick;
        credit_ret = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (d_err !== 1'b1) begin errors++; $display("FAIL cerr_sticky[%0d]: got %b want 1", i, d_err); end
            checks++;
            tick;
        end
        do_reset;
        if (d_err !== 1'b0) begin errors++; $display("FAIL cerr_clear: got %b want 0", d_err); end
        checks++;
    endtask

    task automatic test_alternate;
        logic [5:0] pr [4];
        logic [3:0] exp_obs [4];
        logic [31:0] got_dat;
        logic [5:0]  got_pr;
        pr = '{6'd5, 6'd9, 6'd3, 6'd7};
        exp_obs = '{Q0E, Q1E, Q0E, Q1E};
        do_reset;
        bbq_rdy = 2'b11;
        tick;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 32'hC0DE_0000 + i; in_prior = pr[i];
            if (a_rdy !== 1'b1) begin errors++; $display("FAIL alt_ready[%0d]: got %b want 1", i, a_rdy); end
            checks++;
            tick;
            got_dat = (i % 2 == 0) ? a_dat0 : a_dat1;
            got_pr  = (i % 2 == 0) ? a_pr0 : a_pr1;
            if (a_obs !== exp_obs[i] || got_dat !== 32'hC0DE_0000 + i || got_pr !== pr[i]) begin
                errors++;
                $display("FAIL alt_enq[%0d]: got ops %b data %h prio %0d want %b %h %0d",
                         i, a_obs, got_dat, got_pr, exp_obs[i], 32'hC0DE_0000 + i, pr[i]);
            end
            checks++;
        end
        if (a_occ !== 6'd4) begin errors++; $display("FAIL alt_occ: got %0d want 4", a_occ); end
        checks++;
        // Reset with a request still pending drops it and clears the counters
        rst = 1'b0;
        tick;
        if ({a_obs, a_occ} !== 10'd0) begin
            errors++; $display("FAIL alt_midreset: got ops %b occ %0d want 0000 0", a_obs, a_occ);
        end
        checks++;
        rst = 1'b1; in_valid = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [3:0] exp_obs [5];
        exp_obs = '{Q0E, 4'b1110, Q0E, Q0E, Q1E};
        do_reset;
        bbq_rdy = 2'b11;
        tick;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 32'hD000_0000 + i; in_prior = 6'(10 + i);
            if (c_rdy !== 1'b1) begin errors++; $display("FAIL cap_ready[%0d]: got %b want 1", i, c_rdy); end
            checks++;
            tick;
            if (c_obs !== exp_obs[i]) begin
                errors++; $display("FAIL cap_ops[%0d]: got %b want %b", i, c_obs, exp_obs[i]);
            end
            checks++;
        end
        if ({c_rdy, c_occ} !== {1'b0, 3'd4}) begin
            errors++; $display("FAIL cap_full: got ready %b occ %0d want 0 4", c_rdy, c_occ);
        end
        checks++;
        for (int i = 0; i < 2; i++) begin
            tick;
            if ({c_rdy, c_obs} !== 5'b0_0000) begin
                errors++; $display("FAIL cap_stall[%0d]: got ready %b ops %b want 0 0000", i, c_rdy, c_obs);
            end
            checks++;
        end
        credit_ret = 1'b1;
        tick;
        credit_ret = 1'b0;
        if ({c_rdy, c_obs, c_err} !== 6'b0_0000_0) begin
            errors++; $display("FAIL cap_ret: got ready %b ops %b err %b want 0 0000 0", c_rdy, c_obs, c_err);
        end
        checks++;
        tick;
        if ({c_obs, c_rdy, c_occ} !== {Q0D, 1'b1, 3'd3}) begin
            errors++; $display("FAIL cap_deq: got ops %b ready %b occ %0d want %b 1 3", c_obs, c_rdy, c_occ, Q0D);
        end
        checks++;
        tick;
        if ({c_obs, c_rdy, c_occ} !== {Q0E, 1'b0, 3'd4}) begin
            errors++; $display("FAIL cap_refill: got ops %b ready %b occ %0d want %b 0 4", c_obs, c_rdy, c_occ, Q0E);
        end
        checks++;
        tick;
        if (c_obs !== NONE) begin errors++; $display("FAIL cap_after: got %b want %b", c_obs, NONE); end
        checks++;
        in_valid = 1'b0;
    endtask

    task automatic test_credit_budget;
        logic [3:0] exp_obs [8];
        exp_obs = '{Q0E, 4'b1110, 4'b1011, Q1E, Q0E, Q1E, Q0E, Q1E};
        do_reset;
        bbq_rdy = 2'b11;
        tick;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 32'hE000_0000 + i; in_prior = 6'(20 + i);
            tick;
            if (k_obs !== exp_obs[i]) begin
                errors++; $display("FAIL cred_fill[%0d]: got %b want %b", i, k_obs, exp_obs[i]);
            end
            checks++;
        end
        if (k_occ !== 6'd6) begin errors++; $display("FAIL cred_occ6: got %0d want 6", k_occ); end
        checks++;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (k_obs !== NONE) begin errors++; $display("FAIL cred_empty[%0d]: got %b want %b", i, k_obs, NONE); end
            checks++;
        end
        for (int i = 0; i < 2; i++) begin
            credit_ret = 1'b1;
            tick;
            credit_ret = 1'b0;
            if (k_obs !== NONE) begin errors++; $display("FAIL cred_retcyc[%0d]: got %b want %b", i, k_obs, NONE); end
            checks++;
            tick;
            if (k_obs !== ((i == 0) ? Q1D : Q0D)) begin
                errors++; $display("FAIL cred_deq[%0d]: got %b want %b", i, k_obs, (i == 0) ? Q1D : Q0D);
            end
            checks++;
        end
        if ({k_occ, k_err} !== {6'd4, 1'b0}) begin
            errors++; $display("FAIL cred_final: got occ %0d err %b want 4 0", k_occ, k_err);
        end
        checks++;
        tick;
        if (k_obs !== NONE) begin errors++; $display("FAIL cred_drained: got %b want %b", k_obs, NONE); end
        checks++;
    endtask

    initial begin
        test_reset;
        test_single_queue_rr;
        test_credit_err;
        test_alternate;
        test_back_to_back;
        test_credit_budget;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
